// File: rtl/tempsens_pkg.sv
// Shared types, constants and helpers for the tt03 temperature-sensor conversion sequencer.
package tempsens_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_GATE   = 3'd2,
        ST_CALC   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_CAL    = 3'd5
    } state_t;

    localparam int unsigned TEMP_MAX   = 99;
    localparam int unsigned TEMP_W     = 7;
    localparam int unsigned CAL_W      = 16;

    // Calibration word layout: {offset[11:0], shift[3:0]}
    localparam int unsigned SHIFT_W    = 4;
    localparam int unsigned OFFSET_W   = 12;
    localparam int unsigned SHIFT_LSB  = 0;
    localparam int unsigned OFFSET_LSB = SHIFT_LSB + SHIFT_W;

    // Shift amounts at or above this force the scaled result to zero
    localparam int unsigned SHIFT_ZERO = 12;

    function automatic logic [TEMP_W-1:0] sat_temp(input logic [31:0] r);
        return (r > 32'(TEMP_MAX)) ? TEMP_W'(TEMP_MAX) : TEMP_W'(r);
    endfunction

endpackage

// File: rtl/tempsens_cal_if.sv
// Serial calibration port: pad synchronizers, cal_clk edge detect, 16-bit shift
// register and the shadow register that holds the active offset/shift.
module tempsens_cal_if
    import tempsens_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cal_clk,
    input  logic                cal_dat,
    input  logic                cal_ena,
    output logic                cal_active,
    output logic [OFFSET_W-1:0] offset,
    output logic [SHIFT_W-1:0]  shift
);

    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic [1:0]       ena_sync;
    logic             clk_dly;
    logic             ena_dly;
    logic [CAL_W-1:0] shreg;
    logic [CAL_W-1:0] shadow;
    logic             clk_rise;
    logic             ena_fall;

    assign clk_rise = clk_sync[1] & ~clk_dly;
    assign ena_fall = ena_dly & ~ena_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '0;
            dat_sync <= '0;
            ena_sync <= '0;
            clk_dly  <= 1'b0;
            ena_dly  <= 1'b0;
            shreg    <= '0;
            shadow   <= '0;
        end else begin
            clk_sync <= {clk_sync[0], cal_clk};
            dat_sync <= {dat_sync[0], cal_dat};
            ena_sync <= {ena_sync[0], cal_ena};
            clk_dly  <= clk_sync[1];
            ena_dly  <= ena_sync[1];
            // Data shares the clock's synchronizer depth, so it stays aligned with the edge
            if (clk_rise && ena_sync[1]) begin
                shreg <= {shreg[CAL_W-2:0], dat_sync[1]};
            end
            if (ena_fall) begin
                shadow <= shreg;
            end
        end
    end

    assign cal_active = ena_sync[1];
    assign offset     = shadow[OFFSET_LSB +: OFFSET_W];
    assign shift      = shadow[SHIFT_LSB +: SHIFT_W];

endmodule

// File: rtl/tempsens_conv_ctrl.sv
// Conversion sequencer: gates the oscillator, counts ticks, applies calibration.
// Optional debug byte mux enabled by defining TEMPSENS_CONV_DBG_EN.
module tempsens_conv_ctrl
    import tempsens_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 256,
    parameter int unsigned CNT_W         = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cal_clk,
    input  logic              cal_dat,
    input  logic              cal_ena,
    input  logic              osc_tick,
    output logic              osc_en,
    output logic [TEMP_W-1:0] temp,
    output logic              temp_valid,
    output logic              ovf,
    input  logic [2:0]        dbg_sel,
    output logic [7:0]        dbg_out
);

    localparam int unsigned T_MAX0 = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned T_MAX  = (T_MAX0 > HOLD_CYCLES) ? T_MAX0 : HOLD_CYCLES;
    localparam int unsigned TMR_W  = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam int unsigned DW     = (CNT_W > OFFSET_W) ? CNT_W : OFFSET_W;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [TEMP_W-1:0]    res_q, res_d;
    logic                 res_ovf_q, res_ovf_d;
    logic                 upd_q, upd_d;
    logic                 osc_en_d;

    logic                 cal_active;
    logic [OFFSET_W-1:0]  offset;
    logic [SHIFT_W-1:0]   shift;

    logic [DW-1:0]        cnt_ext;
    logic [DW-1:0]        off_ext;
    logic [DW-1:0]        diff;
    logic [DW-1:0]        quo;
    logic [TEMP_W-1:0]    temp_calc;

    tempsens_cal_if u_cal_if (
        .clk        (CLK),
        .reset      (RESET),
        .cal_clk    (cal_clk),
        .cal_dat    (cal_dat),
        .cal_ena    (cal_ena),
        .cal_active (cal_active),
        .offset     (offset),
        .shift      (shift)
    );

    // Calibrated result: floor at zero, right-shift, clamp to display range
    always_comb begin
        cnt_ext   = DW'(cnt_q);
        off_ext   = DW'(offset);
        diff      = (cnt_ext > off_ext) ? (cnt_ext - off_ext) : '0;
        quo       = (shift >= SHIFT_W'(SHIFT_ZERO)) ? '0 : (diff >> shift);
        temp_calc = sat_temp(32'(quo));
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        res_d      = res_q;
        res_ovf_d  = res_ovf_q;
        upd_d      = 1'b0;
        osc_en_d   = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_SETTLE;
            ST_SETTLE: begin
                osc_en_d   = 1'b1;
                cnt_d      = '0;
                ovf_pend_d = 1'b0;
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) state_d = ST_GATE;
            end
            ST_GATE: begin
                osc_en_d = 1'b1;
                if (osc_tick) begin
                    if (cnt_q == '1) ovf_pend_d = 1'b1;
                    else             cnt_d      = cnt_q + CNT_W'(1);
                end
                if (tmr_q == TMR_W'(GATE_CYCLES - 1)) state_d = ST_CALC;
            end
            ST_CALC: begin
                res_d     = temp_calc;
                res_ovf_d = ovf_pend_q;
                upd_d     = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) state_d = ST_SETTLE;
            end
            ST_CAL:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Calibration pre-empts everything and kills any conversion in flight
        if (cal_active) begin
            state_d  = ST_CAL;
            osc_en_d = 1'b0;
            upd_d    = 1'b0;
        end

        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (state_q == ST_SETTLE || state_q == ST_GATE || state_q == ST_HOLD) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            res_q      <= '0;
            res_ovf_q  <= 1'b0;
            upd_q      <= 1'b0;
            osc_en     <= 1'b0;
            temp       <= '0;
            temp_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            res_q      <= res_d;
            res_ovf_q  <= res_ovf_d;
            upd_q      <= upd_d;
            osc_en     <= osc_en_d;
            temp_valid <= upd_q;
            if (upd_q) begin
                temp <= res_q;
                ovf  <= res_ovf_q;
            end
        end
    end

`ifdef TEMPSENS_CONV_DBG_EN
    logic [7:0]  dbg_d;
    logic [11:0] cnt12;

    assign cnt12 = 12'(cnt_q);

    always_comb begin
        dbg_d = '0;
        case (dbg_sel)
            3'd0:    dbg_d = cnt12[7:0];
            3'd1:    dbg_d = {4'b0, cnt12[11:8]};
            3'd2:    dbg_d = 8'(state_q);
            3'd3:    dbg_d = offset[7:0];
            3'd4:    dbg_d = {offset[11:8], shift};
            3'd5:    dbg_d = {ovf, temp};
            default: dbg_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) dbg_out <= '0;
        else       dbg_out <= dbg_d;
    end
`else
    logic dbg_sel_unused;
    assign dbg_sel_unused = ^dbg_sel;
    assign dbg_out        = '0;
`endif

endmodule

// File: tb/tb_tempsens_conv_ctrl.sv
// Directed bench for tempsens_conv_ctrl: timing, calibration, floor/saturation, clamp, abort.
// Three instances: main (gate 64, 12-bit), narrow counter (6-bit), long gate (200).
module tb_tempsens_conv_ctrl;

    logic       CLK;
    logic       RESET;
    logic       cal_clk, cal_dat, cal_ena;
    logic       tick_a, tick_c;
    logic [2:0] dbg_sel;

    logic       osc_en_a, tv_a, ovf_a;
    logic [6:0] temp_a;
    logic [7:0] dbg_a;
    logic       osc_en_s, tv_s, ovf_s;
    logic [6:0] temp_s;
    logic [7:0] dbg_s;
    logic       osc_en_c, tv_c, ovf_c;
    logic [6:0] temp_c;
    logic [7:0] dbg_c;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int nv_a  = 0;
    int nv_c  = 0;
    bit alt_a = 1'b1;
    bit alt_c = 1'b0;

    tempsens_conv_ctrl #(.GATE_CYCLES(64), .SETTLE_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(12)) dut_a (
        .CLK(CLK), .RESET(RESET), .cal_clk(cal_clk), .cal_dat(cal_dat), .cal_ena(cal_ena),
        .osc_tick(tick_a), .osc_en(osc_en_a), .temp(temp_a), .temp_valid(tv_a), .ovf(ovf_a),
        .dbg_sel(dbg_sel), .dbg_out(dbg_a));

    tempsens_conv_ctrl #(.GATE_CYCLES(64), .SETTLE_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(6)) dut_s (
        .CLK(CLK), .RESET(RESET), .cal_clk(1'b0), .cal_dat(1'b0), .cal_ena(1'b0),
        .osc_tick(1'b1), .osc_en(osc_en_s), .temp(temp_s), .temp_valid(tv_s), .ovf(ovf_s),
        .dbg_sel(dbg_sel), .dbg_out(dbg_s));

    tempsens_conv_ctrl #(.GATE_CYCLES(200), .SETTLE_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(12)) dut_c (
        .CLK(CLK), .RESET(RESET), .cal_clk(cal_clk), .cal_dat(cal_dat), .cal_ena(cal_ena),
        .osc_tick(tick_c), .osc_en(osc_en_c), .temp(temp_c), .temp_valid(tv_c), .ovf(ovf_c),
        .dbg_sel(dbg_sel), .dbg_out(dbg_c));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one edge, sample 1 time unit later, then update tick patterns for the next edge
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (tv_a) nv_a++;
        if (tv_c) nv_c++;
        tick_a = alt_a ? ~tick_a : 1'b1;
        tick_c = alt_c ? ~tick_c : 1'b1;
    endtask

    task automatic cal_bits(input logic [31:0] word, input int nbits);
        logic [31:0] w;
        w = word;
        for (int i = nbits - 1; i >= 0; i--) begin
            cal_dat = w[i];
            repeat (4) step();
            cal_clk = 1'b1;
            repeat (4) step();
            cal_clk = 1'b0;
        end
    endtask

    task automatic cal_load(input logic [31:0] word, input int nbits);
        cal_ena = 1'b1;
        repeat (4) step();
        cal_bits(word, nbits);
        repeat (4) step();
        cal_ena = 1'b0;
    endtask

    task automatic wait_valid(input bit use_c, input int budget, input string tag);
        int n;
        n = 0;
        step();
        while (!(use_c ? tv_c : tv_a) && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 32'(use_c ? tv_c : tv_a), 32'd1);
    endtask

    initial begin
        RESET   = 1'b1;
        cal_clk = 1'b0;
        cal_dat = 1'b0;
        cal_ena = 1'b0;
        tick_a  = 1'b0;
        tick_c  = 1'b1;
        dbg_sel = 3'd2;
        repeat (5) step();
        check_eq("rst_osc_en", 32'(osc_en_a), 32'd0);
        check_eq("rst_temp", 32'(temp_a), 32'd0);
        check_eq("rst_valid", 32'(tv_a), 32'd0);
        check_eq("rst_ovf", 32'(ovf_a), 32'd0);
        check_eq("rst_dbg", 32'(dbg_a), 32'd0);
        RESET = 1'b0;
        cyc   = -1;

        // Free-running conversions on all three instances
        for (int c = 0; c <= 264; c++) begin
            step();
            if (c <= 78) begin
                check_eq("osc_en_a", 32'(osc_en_a), 32'((c >= 1 && c <= 68) || c == 78));
                check_eq("valid_a", 32'(tv_a), 32'(c == 70));
            end
            if (c == 30) begin
`ifdef TEMPSENS_CONV_DBG_EN
                check_eq("dbg_state_gate", 32'(dbg_a), 32'h02);
`else
                check_eq("dbg_off", 32'(dbg_a), 32'h00);
`endif
            end
            if (c == 70) begin
                check_eq("conv1_temp_a", 32'(temp_a), 32'd32);
                check_eq("conv1_ovf_a", 32'(ovf_a), 32'd0);
                check_eq("sat_valid_s", 32'(tv_s), 32'd1);
                check_eq("sat_temp_s", 32'(temp_s), 32'd63);
                check_eq("sat_ovf_s", 32'(ovf_s), 32'd1);
            end
            if (c == 78) alt_a = 1'b0;
            if (c == 147) begin
                check_eq("conv2_valid_a", 32'(tv_a), 32'd1);
                check_eq("conv2_temp_a", 32'(temp_a), 32'd64);
                check_eq("conv2_ovf_a", 32'(ovf_a), 32'd0);
                alt_a = 1'b1;
            end
            if (c == 206) begin
                check_eq("clamp_valid_c", 32'(tv_c), 32'd1);
                check_eq("clamp_temp_c", 32'(temp_c), 32'd99);
                check_eq("clamp_ovf_c", 32'(ovf_c), 32'd0);
                alt_c = 1'b1;
            end
            if (c == 224) begin
                check_eq("conv3_valid_a", 32'(tv_a), 32'd1);
                check_eq("conv3_temp_a", 32'(temp_a), 32'd32);
            end
        end

        // Abort at gate cycle 30 of the fourth conversion, then load 0x0143
        cal_ena = 1'b1;
        begin
            int va0, vc0;
            va0 = nv_a;
            vc0 = nv_c;
            step();
            step();
            check_eq("abort_osc_still_on", 32'(osc_en_a), 32'd1);
            step();
            check_eq("abort_osc_off", 32'(osc_en_a), 32'd0);
            cal_bits(32'h0143, 16);
            repeat (4) step();
            check_eq("cal_osc_off", 32'(osc_en_a), 32'd0);
            cal_ena = 1'b0;
            check_eq("abort_no_valid_a", 32'(nv_a - va0), 32'd0);
            check_eq("abort_no_valid_c", 32'(nv_c - vc0), 32'd0);
            check_eq("abort_temp_a", 32'(temp_a), 32'd32);
            check_eq("abort_temp_c", 32'(temp_c), 32'd99);
        end

        wait_valid(1'b0, 300, "cal_wait_a");
        check_eq("cal_temp_a", 32'(temp_a), 32'd1);
        check_eq("cal_ovf_a", 32'(ovf_a), 32'd0);
`ifdef TEMPSENS_CONV_DBG_EN
        dbg_sel = 3'd4;
        repeat (2) step();
        check_eq("dbg_offhi_shift", 32'(dbg_a), 32'h03);
        dbg_sel = 3'd3;
        repeat (2) step();
        check_eq("dbg_offlo", 32'(dbg_a), 32'h14);
`else
        check_eq("dbg_off_cal", 32'(dbg_a), 32'h00);
`endif
        wait_valid(1'b1, 400, "cal_wait_c");
        check_eq("cal_temp_c", 32'(temp_c), 32'd10);
        check_eq("cal_ovf_c", 32'(ovf_c), 32'd0);

        // 20 bits shifted: only the last 16 (offset 200, shift 0) take effect
        cal_load(32'h000F_0C80, 20);
        wait_valid(1'b0, 300, "floor_wait_a");
        check_eq("floor_temp_a", 32'(temp_a), 32'd0);
        wait_valid(1'b1, 400, "floor_wait_c");
        check_eq("floor_temp_c", 32'(temp_c), 32'd0);
        check_eq("floor_ovf_c", 32'(ovf_c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
